// File: rtl/usr_pkg.sv
// Shared types and mode codes for the universal shift register.
// USR_ROTATE_EN enables the ROL/ROR modes; without it they act as HOLD.
package usr_pkg;

   localparam logic [2:0] MODE_HOLD = 3'd0;
   localparam logic [2:0] MODE_LOAD = 3'd1;
   localparam logic [2:0] MODE_SHL  = 3'd2;
   localparam logic [2:0] MODE_SHR  = 3'd3;
   localparam logic [2:0] MODE_ASR  = 3'd4;
   localparam logic [2:0] MODE_ROL  = 3'd5;
   localparam logic [2:0] MODE_ROR  = 3'd6;
   localparam logic [2:0] MODE_RSVD = 3'd7;

   typedef enum logic [2:0] {
      ModeHold = MODE_HOLD,
      ModeLoad = MODE_LOAD,
      ModeShl  = MODE_SHL,
      ModeShr  = MODE_SHR,
      ModeAsr  = MODE_ASR,
      ModeRol  = MODE_ROL,
      ModeRor  = MODE_ROR,
      ModeRsvd = MODE_RSVD
   } usr_mode_e;

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StDone
   } usr_state_e;

   // Modes that walk through SHIFT one bit per edge.
   function automatic logic is_step_mode(usr_mode_e m);
      case (m)
         ModeShl, ModeShr, ModeAsr: return 1'b1;
`ifdef USR_ROTATE_EN
         ModeRol, ModeRor:          return 1'b1;
`endif
         default:                   return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/usr_step.sv
// Combinational single-bit shift/rotate step.
// Rotate paths exist only when USR_ROTATE_EN is defined.
module usr_step
   import usr_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] q,
   input  usr_mode_e        mode,
   input  logic             ser_in_l,
   input  logic             ser_in_r,
   output logic [WIDTH-1:0] next_q,
   output logic             out_bit
);

   always_comb begin
      next_q  = q;
      out_bit = 1'b0;
      case (mode)
         ModeShl: begin
            next_q  = {q[WIDTH-2:0], ser_in_l};
            out_bit = q[WIDTH-1];
         end
         ModeShr: begin
            next_q  = {ser_in_r, q[WIDTH-1:1]};
            out_bit = q[0];
         end
         ModeAsr: begin
            next_q  = {q[WIDTH-1], q[WIDTH-1:1]};
            out_bit = q[0];
         end
`ifdef USR_ROTATE_EN
         ModeRol: begin
            next_q  = {q[WIDTH-2:0], q[WIDTH-1]};
            out_bit = q[WIDTH-1];
         end
         ModeRor: begin
            next_q  = {q[0], q[WIDTH-1:1]};
            out_bit = q[0];
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: load, hold, and multi-step shift/rotate with busy/done handshake.
// Define USR_ROTATE_EN to include the ROL/ROR modes.
module univ_shift_reg
   import usr_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned AMT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       mode,
   input  logic [AMT_W-1:0] amt,
   input  logic [WIDTH-1:0] load_data,
   input  logic             ser_in_l,
   input  logic             ser_in_r,
   output logic [WIDTH-1:0] q,
   output logic             ser_out,
   output logic             busy,
   output logic             done
);

   usr_state_e       state_q, state_d;
   usr_mode_e        mode_q, mode_d;
   logic [AMT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             ser_q, ser_d;

   logic [WIDTH-1:0] step_q;
   logic             step_bit;
   logic [AMT_W-1:0] amt_clamped;
   usr_mode_e        mode_in;

   assign mode_in     = usr_mode_e'(mode);
   assign amt_clamped = (amt > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : amt;

   usr_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .q        (q_q),
      .mode     (mode_q),
      .ser_in_l (ser_in_l),
      .ser_in_r (ser_in_r),
      .next_q   (step_q),
      .out_bit  (step_bit)
   );

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      ser_d   = ser_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               mode_d = mode_in;
               cnt_d  = amt_clamped;
               if (mode_in == ModeLoad) begin
                  q_d     = load_data;
                  state_d = StDone;
               end else if (is_step_mode(mode_in) && (amt != '0)) begin
                  state_d = StShift;
               end else begin
                  state_d = StDone;
               end
            end
         end
         StShift: begin
            q_d   = step_q;
            ser_d = step_bit;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == AMT_W'(1)) state_d = StDone;
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         mode_q  <= ModeHold;
         cnt_q   <= '0;
         q_q     <= '0;
         ser_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         ser_q   <= ser_d;
      end
   end

   assign q       = q_q;
   assign ser_out = ser_q;
   assign busy    = (state_q != StIdle);
   assign done    = (state_q == StDone);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: directed cases plus random operations
// compared against a closed-form whole-operation model.
module tb_univ_shift_reg;

   localparam int W     = 8;
   localparam int AMT_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [2:0]       mode;
   logic [AMT_W-1:0] amt;
   logic [W-1:0]     load_data;
   logic             ser_in_l;
   logic             ser_in_r;
   logic [W-1:0]     q;
   logic             ser_out;
   logic             busy;
   logic             done;

   int errors = 0;
   int checks = 0;

   // Model state
   int unsigned m_q   = 0;
   int unsigned m_ser = 0;

   univ_shift_reg #(
      .WIDTH (W),
      .AMT_W (AMT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .mode      (mode),
      .amt       (amt),
      .load_data (load_data),
      .ser_in_l  (ser_in_l),
      .ser_in_r  (ser_in_r),
      .q         (q),
      .ser_out   (ser_out),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

`ifdef USR_ROTATE_EN
   localparam bit ROT = 1'b1;
`else
   localparam bit ROT = 1'b0;
`endif

   // Whole-operation result from the mode rules, using plain arithmetic on 8-bit values.
   task automatic model(input int md, input int a, input int unsigned ld, input bit sl,
                        input bit sr, output int lat);
      int          k;
      int unsigned v, top;
      bit          stepping;
      k = (a > W) ? W : a;
      v = m_q;
      top = 255 & ~(255 >> k);
      stepping = (md == 2) || (md == 3) || (md == 4) || (ROT && (md == 5 || md == 6));
      lat = 1;
      if (md == 1) begin
         m_q = ld;
      end else if (stepping && k != 0) begin
         lat = k + 1;
         case (md)
            2: begin
               m_q   = ((v << k) | (sl ? ((1 << k) - 1) : 0)) & 255;
               m_ser = (v >> (W - k)) & 1;
            end
            3: begin
               m_q   = (v >> k) | (sr ? top : 0);
               m_ser = (v >> (k - 1)) & 1;
            end
            4: begin
               m_q   = (v >> k) | ((v >> 7) != 0 ? top : 0);
               m_ser = (v >> (k - 1)) & 1;
            end
            5: begin
               m_q   = ((v << k) | (v >> (W - k))) & 255;
               m_ser = m_q & 1;
            end
            default: begin
               m_q   = ((v >> k) | (v << (W - k))) & 255;
               m_ser = (m_q >> 7) & 1;
            end
         endcase
      end
   endtask

   // Called with inputs settable before the next rising edge; ends #1 after the edge
   // on which done drops back to 0.
   task automatic run_op(input string tag, input int md, input int a, input int unsigned ld,
                         input bit sl, input bit sr, input bit poke_start);
      int lat, cyc;
      model(md, a, ld, sl, sr, lat);
      mode      = 3'(md);
      amt       = AMT_W'(a);
      load_data = W'(ld);
      ser_in_l  = sl;
      ser_in_r  = sr;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc = 1;
      while (!done && cyc < 20) begin
         if (poke_start && cyc == 2) start = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
         cyc++;
      end
      check({tag, ".latency"}, cyc, lat);
      check({tag, ".busy"}, busy, 1);
      check({tag, ".q"}, q, m_q);
      check({tag, ".ser_out"}, ser_out, m_ser);
      @(posedge clk);
      #1;
      check({tag, ".done_drop"}, {busy, done}, 0);
   endtask

   initial begin
      int dummy;
      rst = 1'b1; start = 1'b0; mode = '0; amt = '0; load_data = '0;
      ser_in_l = 1'b0; ser_in_r = 1'b0;
      #12;
      check("reset.q", q, 0);
      check("reset.flags", {ser_out, busy, done}, 0);
      @(negedge clk);
      rst = 1'b0;

      run_op("load_a5", 1, 0, 'hA5, 0, 0, 0);
      run_op("load_81", 1, 0, 'h81, 0, 0, 0);
      run_op("shl3", 2, 3, 0, 1, 0, 0);
      run_op("load_80", 1, 0, 'h80, 0, 0, 0);
      run_op("asr9", 4, 9, 0, 0, 0, 0);
      run_op("load_12", 1, 0, 'h12, 0, 0, 0);
      run_op("ror4", 6, 4, 0, 0, 0, 0);
      run_op("shr0", 3, 0, 0, 1, 1, 0);
      run_op("shl6_poke", 2, 6, 0, 1, 0, 1);
      run_op("hold", 0, 5, 'h3C, 1, 1, 0);
      run_op("rsvd", 7, 3, 'h3C, 1, 1, 0);

      // Reset in the middle of a SHL by 5, after two steps
      run_op("load_5a", 1, 0, 'h5A, 0, 0, 0);
      mode = 3'd2; amt = AMT_W'(5); ser_in_l = 1'b1; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midrst.q", q, 0);
      check("midrst.flags", {ser_out, busy, done}, 0);
      m_q = 0;
      m_ser = 0;
      dummy = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         if (done) dummy++;
      end
      check("midrst.no_done", dummy, 0);
      @(negedge clk);
      rst = 1'b0;
      run_op("after_rst", 2, 2, 0, 1, 0, 0);

      for (int i = 0; i < 40; i++) begin
         run_op("rand", int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                $urandom_range(0, 255), 1'($urandom), 1'($urandom), 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
